// File: rtl/memory_arbiter.sv
// Shared RAM port arbiter: one cache transaction at a time, dcache over icache,
// round-robin within each class, with write-invalidate broadcast on dcache writes.
module memory_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0][WORD_W-1:0]   iaddr,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]   daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0]               dwait,
    output logic [CPUS-1:0][WORD_W-1:0]   iload,
    output logic [CPUS-1:0][WORD_W-1:0]   dload,
    output logic [CPUS-1:0]               ccwait,
    output logic [CPUS-1:0]               ccinv,
    output logic [CPUS-1:0][WORD_W-1:0]   ccsnoopaddr,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [WORD_W-1:0]             ramaddr,
    output logic [WORD_W-1:0]             ramstore,
    input  logic [WORD_W-1:0]             ramload,
    input  logic [1:0]                    ramstate
);

    localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RS_ACCESS = 2'd2;

    typedef enum logic { IDLE, GRANT } state_t;
    typedef enum logic { OWN_I, OWN_D } own_t;

    state_t           state_q, state_d;
    own_t             own_type_q, own_type_d;
    logic [IDX_W-1:0] own_cpu_q, own_cpu_d;
    logic [IDX_W-1:0] dptr_q, dptr_d;
    logic [IDX_W-1:0] iptr_q, iptr_d;

    logic [IDX_W:0]   dpick, ipick;
    logic             own_active;
    logic             own_write;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [CPUS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int idx;
        res = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CPUS;
            if (req[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] win);
        return IDX_W'((int'(win) + 1) % CPUS);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            own_type_q <= OWN_D;
            own_cpu_q  <= '0;
            dptr_q     <= '0;
            iptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            own_type_q <= own_type_d;
            own_cpu_q  <= own_cpu_d;
            dptr_q     <= dptr_d;
            iptr_q     <= iptr_d;
        end
    end

    always_comb begin
        for (int j = 0; j < CPUS; j++) begin
            iload[j] = ramload;
            dload[j] = ramload;
        end
    end

    always_comb begin
        state_d     = state_q;
        own_type_d  = own_type_q;
        own_cpu_d   = own_cpu_q;
        dptr_d      = dptr_q;
        iptr_d      = iptr_q;
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        own_active  = 1'b0;
        own_write   = 1'b0;
        dpick       = rr_pick(dREN | dWEN, dptr_q);
        ipick       = rr_pick(iREN, iptr_q);

        case (state_q)
            IDLE: begin
                if (dpick[IDX_W]) begin
                    state_d    = GRANT;
                    own_type_d = OWN_D;
                    own_cpu_d  = dpick[IDX_W-1:0];
                    dptr_d     = next_ptr(dpick[IDX_W-1:0]);
                end else if (ipick[IDX_W]) begin
                    state_d    = GRANT;
                    own_type_d = OWN_I;
                    own_cpu_d  = ipick[IDX_W-1:0];
                    iptr_d     = next_ptr(ipick[IDX_W-1:0]);
                end
            end
            GRANT: begin
                if (own_type_q == OWN_D) begin
                    ramREN     = dREN[own_cpu_q];
                    ramWEN     = dWEN[own_cpu_q];
                    ramaddr    = daddr[own_cpu_q];
                    ramstore   = dstore[own_cpu_q];
                    own_active = dREN[own_cpu_q] | dWEN[own_cpu_q];
                    own_write  = dWEN[own_cpu_q];
                end else begin
                    ramREN     = iREN[own_cpu_q];
                    ramaddr    = iaddr[own_cpu_q];
                    own_active = iREN[own_cpu_q];
                end

                // A dropped request aborts silently; ACCESS only counts while the owner still asks.
                if (!own_active) begin
                    state_d = IDLE;
                end else if (ramstate == RS_ACCESS) begin
                    state_d = IDLE;
                    if (own_type_q == OWN_D) dwait[own_cpu_q] = 1'b0;
                    else                     iwait[own_cpu_q] = 1'b0;
                    if (own_write) begin
                        for (int j = 0; j < CPUS; j++) begin
                            if (IDX_W'(j) != own_cpu_q) begin
                                ccinv[j]       = 1'b1;
                                ccsnoopaddr[j] = daddr[own_cpu_q];
                            end
                        end
                    end
                end else if (own_write) begin
                    for (int j = 0; j < CPUS; j++) begin
                        if (IDX_W'(j) != own_cpu_q) ccwait[j] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter (CPUS=2): reset, single read, priority,
// round-robin, write invalidate, abort, ERROR retry and reset mid-transaction.
module tb_memory_arbiter;

    localparam int CPUS   = 2;
    localparam int WORD_W = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic [CPUS-1:0]             iREN, dREN, dWEN;
    logic [CPUS-1:0][WORD_W-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]             iwait, dwait, ccwait, ccinv;
    logic [CPUS-1:0][WORD_W-1:0] iload, dload, ccsnoopaddr;
    logic                        ramREN, ramWEN;
    logic [WORD_W-1:0]           ramaddr, ramstore, ramload;
    logic [1:0]                  ramstate;

    int checks   = 0;
    int failures = 0;

    memory_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iwait"},  64'(iwait), 64'h3);
        chk({tag, "_dwait"},  64'(dwait), 64'h3);
        chk({tag, "_ramen"},  64'({ramREN, ramWEN}), 64'h0);
        chk({tag, "_ramaddr"}, 64'(ramaddr), 64'h0);
        chk({tag, "_ramstore"}, 64'(ramstore), 64'h0);
        chk({tag, "_ccwait"}, 64'(ccwait), 64'h0);
        chk({tag, "_ccinv"},  64'(ccinv), 64'h0);
        chk({tag, "_snoop"},  64'(ccsnoopaddr), 64'h0);
    endtask

    initial begin
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (3) cyc();
        settle();
        chk_reset_outputs("rst");
        RST = 1'b0;

        // Single icache read, ACCESS on the 2nd grant cycle
        cyc(); iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = FREE; settle();
        chk("rd_idle_ren", 64'(ramREN), 64'h0);
        cyc(); ramstate = BUSY; settle();
        chk("rd_g1_ren", 64'(ramREN), 64'h1);
        chk("rd_g1_addr", 64'(ramaddr), 64'h40);
        chk("rd_g1_iwait", 64'(iwait), 64'h3);
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; settle();
        chk("rd_g2_iwait", 64'(iwait), 64'h2);
        chk("rd_g2_iload", 64'(iload[0]), 64'hDEADBEEF);
        chk("rd_g2_dload", 64'(dload[1]), 64'hDEADBEEF);
        cyc(); iREN[0] = 1'b0; ramstate = FREE; settle();
        chk("rd_bub_iwait", 64'(iwait), 64'h3);
        chk("rd_bub_ren", 64'(ramREN), 64'h0);

        // Priority: dcache CPU1 beats icache CPU0
        cyc(); iREN[0] = 1'b1; iaddr[0] = 32'h200; dREN[1] = 1'b1; daddr[1] = 32'h100; settle();
        cyc(); ramstate = ACCESS; settle();
        chk("pri_d_addr", 64'(ramaddr), 64'h100);
        chk("pri_d_dwait", 64'(dwait), 64'h1);
        chk("pri_d_iwait", 64'(iwait), 64'h3);
        cyc(); dREN[1] = 1'b0; ramstate = FREE; settle();
        chk("pri_bub_ren", 64'(ramREN), 64'h0);
        cyc(); ramstate = ACCESS; settle();
        chk("pri_i_addr", 64'(ramaddr), 64'h200);
        chk("pri_i_iwait", 64'(iwait), 64'h2);
        cyc(); iREN[0] = 1'b0; ramstate = FREE; settle();

        // Round-robin among continuous dcache readers
        cyc(); dREN = 2'b11; daddr[0] = 32'hA0; daddr[1] = 32'hB0; ramstate = ACCESS; settle();
        for (int n = 0; n < 4; n++) begin
            cyc(); settle();
            chk("rr_addr", 64'(ramaddr), (n % 2 == 0) ? 64'hA0 : 64'hB0);
            chk("rr_dwait", 64'(dwait), (n % 2 == 0) ? 64'h2 : 64'h1);
            cyc(); settle();
            chk("rr_bub_ren", 64'(ramREN), 64'h0);
        end
        dREN = 2'b00; ramstate = FREE;
        cyc(); settle();

        // Write with invalidate broadcast
        cyc(); dWEN[0] = 1'b1; daddr[0] = 32'h1230; dstore[0] = 32'h55; ramstate = BUSY; settle();
        cyc(); settle();
        chk("wr_busy_ccwait", 64'(ccwait), 64'h2);
        chk("wr_busy_wen", 64'(ramWEN), 64'h1);
        chk("wr_busy_ccinv", 64'(ccinv), 64'h0);
        chk("wr_busy_dwait", 64'(dwait), 64'h3);
        cyc(); ramstate = ACCESS; settle();
        chk("wr_acc_wen", 64'(ramWEN), 64'h1);
        chk("wr_acc_store", 64'(ramstore), 64'h55);
        chk("wr_acc_ccinv", 64'(ccinv), 64'h2);
        chk("wr_acc_snoop1", 64'(ccsnoopaddr[1]), 64'h1230);
        chk("wr_acc_snoop0", 64'(ccsnoopaddr[0]), 64'h0);
        chk("wr_acc_dwait", 64'(dwait), 64'h2);
        chk("wr_acc_ccwait", 64'(ccwait), 64'h0);
        cyc(); dWEN[0] = 1'b0; ramstate = FREE; settle();
        chk("wr_post_ccinv", 64'(ccinv), 64'h0);
        chk("wr_post_snoop", 64'(ccsnoopaddr), 64'h0);

        // Abort: CPU1 drops dREN after two stall cycles (one of them ERROR)
        cyc(); dREN[1] = 1'b1; daddr[1] = 32'h300; ramstate = BUSY; settle();
        cyc(); settle();
        chk("ab_g1_ren", 64'(ramREN), 64'h1);
        chk("ab_g1_dwait", 64'(dwait), 64'h3);
        cyc(); ramstate = ERROR; settle();
        chk("ab_err_dwait", 64'(dwait), 64'h3);
        chk("ab_err_addr", 64'(ramaddr), 64'h300);
        cyc(); dREN[1] = 1'b0; ramstate = BUSY; settle();
        chk("ab_drop_ren", 64'(ramREN), 64'h0);
        chk("ab_drop_dwait", 64'(dwait), 64'h3);
        chk("ab_drop_ccinv", 64'(ccinv), 64'h0);
        cyc(); ramstate = ACCESS; settle();
        chk("ab_idle_dwait", 64'(dwait), 64'h3);
        chk("ab_idle_ren", 64'(ramREN), 64'h0);
        cyc(); ramstate = FREE; settle();

        // Reset while CPU0 holds a write grant; pointers must return to 0
        cyc(); dWEN[0] = 1'b1; daddr[0] = 32'h400; ramstate = BUSY; settle();
        cyc(); settle();
        chk("rm_ccwait", 64'(ccwait), 64'h2);
        RST = 1'b1;
        cyc(); RST = 1'b0; dWEN[0] = 1'b0; settle();
        chk_reset_outputs("rm");
        dREN = 2'b11; daddr[0] = 32'hA0; daddr[1] = 32'hB0; ramstate = ACCESS;
        cyc(); settle();
        chk("rm_d_addr", 64'(ramaddr), 64'hA0);
        chk("rm_d_dwait", 64'(dwait), 64'h2);
        cyc(); dREN = 2'b00; iREN = 2'b11; iaddr[0] = 32'hC0; iaddr[1] = 32'hD0; settle();
        chk("rm_bub_ren", 64'(ramREN), 64'h0);
        cyc(); settle();
        chk("rm_i_addr", 64'(ramaddr), 64'hC0);
        chk("rm_i_iwait", 64'(iwait), 64'h2);
        cyc(); iREN = 2'b00; ramstate = FREE; settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
